// File: rtl/gb_pkg.sv
// Shared Game Boy definitions: IO register addresses, OAM geometry, DMA state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gb_pkg;

  // IO register addresses decoded by the IO select logic
  localparam logic [15:0] ADR_P1   = 16'hff00;
  localparam logic [15:0] ADR_SB   = 16'hff01;
  localparam logic [15:0] ADR_SC   = 16'hff02;
  localparam logic [15:0] ADR_DIV  = 16'hff04;
  localparam logic [15:0] ADR_TIMA = 16'hff05;
  localparam logic [15:0] ADR_IF   = 16'hff0f;
  localparam logic [15:0] ADR_LCDC = 16'hff40;
  localparam logic [15:0] ADR_STAT = 16'hff41;
  localparam logic [15:0] ADR_LY   = 16'hff44;
  localparam logic [15:0] ADR_DMA  = 16'hff46;
  localparam logic [15:0] ADR_BGP  = 16'hff47;
  localparam logic [15:0] ADR_IE   = 16'hffff;

  // OAM is 40 sprites x 4 bytes
  localparam int OAM_LEN = 160;

  // OAM DMA engine states
  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_XFER  = 2'd2,
    DMA_DRAIN = 2'd3
  } dma_state_t;

endpackage

// File: rtl/gb_oam_dma.sv
// OAM DMA engine behind 0xff46: copies LEN bytes from XX00.. into OAM 0x00.., one byte per M-cycle.
// Latency: active the M-cycle after the write, first read START_DELAY M-cycles later, each byte lands in OAM 1 M-cycle after its read.
// Backpressure: none; the arbiter grants this master outright while active, and ce=0 freezes all state and outputs.
module gb_oam_dma
  import gb_pkg::*;
#(
  parameter int LEN         = OAM_LEN,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        sel,
  input  logic        wr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        active,
  output logic [15:0] bus_adr,
  output logic        bus_rd,
  input  logic [7:0]  bus_din,
  output logic [7:0]  oam_adr,
  output logic        oam_wr,
  output logic [7:0]  oam_dout
);

  localparam logic [7:0] LAST_IDX   = 8'(LEN - 1);
  localparam logic [7:0] DELAY_INIT = 8'(START_DELAY);

  // Echo RAM (E000-FDFF) mirrors C000-DDFF, so high pages fold down by 0x20.
  function automatic logic [7:0] fold(input logic [7:0] h);
    return (h >= 8'hE0) ? (h - 8'h20) : h;
  endfunction

  dma_state_t  state_q;
  logic [7:0]  src_hi_q;
  logic [7:0]  dout_q;
  logic [7:0]  idx_q;
  logic [7:0]  idx_d;
  logic [7:0]  dly_q;
  logic [7:0]  dly_d;
  logic [7:0]  data_q;
  logic        active_q;
  logic        bus_rd_q;
  logic [15:0] bus_adr_q;
  logic        oam_wr_q;
  logic [7:0]  oam_adr_q;
  logic        start;

  // A register write wins over whatever the engine is doing this M-cycle.
  assign start = sel & wr;
  assign idx_d = idx_q + 8'd1;
  assign dly_d = dly_q - 8'd1;

  // Engine FSM; every output register is loaded with the value for the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= DMA_IDLE;
      src_hi_q  <= 8'h00;
      dout_q    <= 8'h00;
      idx_q     <= 8'h00;
      dly_q     <= 8'h00;
      data_q    <= 8'h00;
      active_q  <= 1'b0;
      bus_rd_q  <= 1'b0;
      bus_adr_q <= 16'h0000;
      oam_wr_q  <= 1'b0;
      oam_adr_q <= 8'h00;
    end else if (ce) begin
      if (start) begin
        // (Re)start: any capture or OAM write of an older transfer is dropped here.
        src_hi_q <= din;
        dout_q   <= din;
        idx_q    <= 8'h00;
        dly_q    <= DELAY_INIT;
        active_q <= 1'b1;
        oam_wr_q <= 1'b0;
        if (START_DELAY == 0) begin
          state_q   <= DMA_XFER;
          bus_rd_q  <= 1'b1;
          bus_adr_q <= {fold(din), 8'h00};
        end else begin
          state_q  <= DMA_START;
          bus_rd_q <= 1'b0;
        end
      end else begin
        case (state_q)
          DMA_IDLE: begin
            active_q <= 1'b0;
            bus_rd_q <= 1'b0;
            oam_wr_q <= 1'b0;
          end
          DMA_START: begin
            dly_q <= dly_d;
            if (dly_d == 8'h00) begin
              state_q   <= DMA_XFER;
              bus_rd_q  <= 1'b1;
              bus_adr_q <= {fold(src_hi_q), 8'h00};
            end
          end
          DMA_XFER: begin
            // The byte read now is written to OAM in the following M-cycle.
            data_q    <= bus_din;
            oam_wr_q  <= 1'b1;
            oam_adr_q <= idx_q;
            if (idx_q == LAST_IDX) begin
              state_q  <= DMA_DRAIN;
              bus_rd_q <= 1'b0;
            end else begin
              idx_q     <= idx_d;
              bus_adr_q <= {fold(src_hi_q), idx_d};
            end
          end
          DMA_DRAIN: begin
            state_q  <= DMA_IDLE;
            active_q <= 1'b0;
            oam_wr_q <= 1'b0;
          end
          default: begin
            state_q  <= DMA_IDLE;
            active_q <= 1'b0;
            bus_rd_q <= 1'b0;
            oam_wr_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout     = dout_q;
  assign active   = active_q;
  assign bus_adr  = bus_adr_q;
  assign bus_rd   = bus_rd_q;
  assign oam_adr  = oam_adr_q;
  assign oam_wr   = oam_wr_q;
  assign oam_dout = data_q;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Self-checking bench for gb_oam_dma: table of full transfers plus restart, drain-collision and reset sequences.
// Latency: checks exact M-cycle offsets of first read, first/last OAM write and active span.
// Backpressure: ce gating is randomised per clock in the gated table entry.
`timescale 1ns/1ps
module tb_gb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic        sel = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        active;
  logic [15:0] bus_adr;
  logic        bus_rd;
  logic [7:0]  bus_din;
  logic [7:0]  oam_adr;
  logic        oam_wr;
  logic [7:0]  oam_dout;

  always #5 clk = ~clk;

  gb_oam_dma #(.LEN(160), .START_DELAY(1)) dut (
    .clk(clk), .reset(reset), .ce(ce), .sel(sel), .wr(wr), .din(din),
    .dout(dout), .active(active), .bus_adr(bus_adr), .bus_rd(bus_rd),
    .bus_din(bus_din), .oam_adr(oam_adr), .oam_wr(oam_wr), .oam_dout(oam_dout)
  );

  // Model memory contents: an address-dependent pattern.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] fold_m(input logic [7:0] h);
    return (h >= 8'hE0) ? (h - 8'h20) : h;
  endfunction

  assign bus_din = mem(bus_adr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples each M-cycle on the falling edge, away from the active edge.
  int          mcnt = 0;
  int          wr_m = 0;
  int          first_rd_m = -1;
  int          first_wr_m = -1;
  int          last_wr_m = -1;
  int          act_cnt = 0;
  int          act_total = 0;
  int          wr_cnt = 0;
  int          oam_total = 0;
  int          bad = 0;
  int          idle_gap = 0;
  logic [15:0] first_rd_adr = 16'h0000;
  logic [7:0]  cur_hi = 8'h00;
  logic [7:0]  shadow [160];

  always @(negedge clk) begin
    if (ce && reset) begin
      mcnt++;
      if (active) begin
        act_cnt++;
        act_total++;
        if (!bus_rd && !oam_wr) idle_gap++;
      end
      if (bus_rd) begin
        if (first_rd_m < 0) begin
          first_rd_m   = mcnt;
          first_rd_adr = bus_adr;
        end
        if (bus_adr[15:8] != cur_hi || bus_adr[7:0] >= 8'd160) bad++;
      end
      if (oam_wr) begin
        if (first_wr_m < 0) first_wr_m = mcnt;
        last_wr_m = mcnt;
        oam_total++;
        if (oam_adr != 8'(wr_cnt) || oam_dout != mem({cur_hi, oam_adr})) bad++;
        if (oam_adr < 8'd160) shadow[oam_adr] = oam_dout;
        else bad++;
        wr_cnt++;
      end
      if (sel && wr) begin
        wr_m       = mcnt;
        cur_hi     = fold_m(din);
        first_rd_m = -1;
        first_wr_m = -1;
        last_wr_m  = -1;
        act_cnt    = 0;
        wr_cnt     = 0;
        idle_gap   = 0;
      end
    end
  end

  bit gate = 1'b0;

  // One clock; returns whether it was a ce (M-cycle) clock.
  task automatic step(output bit took);
    ce   = gate ? 1'($urandom_range(0, 1)) : 1'b1;
    took = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic mstep();
    bit t;
    int n = 0;
    do begin
      step(t);
      n++;
    end while (!t && n < 1000);
  endtask

  task automatic do_write(input logic [7:0] d);
    sel = 1'b1;
    wr  = 1'b1;
    din = d;
    mstep();
    sel = 1'b0;
    wr  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (active && n < budget) begin
      mstep();
      n++;
    end
    check(name, 32'(active), 32'd0);
  endtask

  function automatic int oam_mismatches(input logic [7:0] hi);
    int m = 0;
    for (int i = 0; i < 160; i++)
      if (shadow[i] !== mem({hi, 8'(i)})) m++;
    return m;
  endfunction

  typedef struct {
    logic [7:0] val;
    bit         gated;
    logic [7:0] exp_hi;
  } vec_t;

  vec_t vecs [6];

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad0;
    int a0;
    int m0;
    int w0;
    int n;

    vecs[0] = '{val: 8'hC1, gated: 1'b0, exp_hi: 8'hC1};
    vecs[1] = '{val: 8'hFE, gated: 1'b0, exp_hi: 8'hDE};
    vecs[2] = '{val: 8'h12, gated: 1'b0, exp_hi: 8'h12};
    vecs[3] = '{val: 8'hE0, gated: 1'b0, exp_hi: 8'hC0};
    vecs[4] = '{val: 8'hFF, gated: 1'b0, exp_hi: 8'hDF};
    vecs[5] = '{val: 8'hC1, gated: 1'b1, exp_hi: 8'hC1};

    // Reset state
    reset = 1'b0;
    repeat (3) mstep();
    check("rst_active",   32'(active),   32'd0);
    check("rst_bus_rd",   32'(bus_rd),   32'd0);
    check("rst_oam_wr",   32'(oam_wr),   32'd0);
    check("rst_bus_adr",  32'(bus_adr),  32'h0000);
    check("rst_oam_adr",  32'(oam_adr),  32'h00);
    check("rst_oam_dout", 32'(oam_dout), 32'h00);
    check("rst_dout",     32'(dout),     32'h00);
    reset = 1'b1;
    repeat (2) mstep();

    // Table of complete transfers
    for (int v = 0; v < 6; v++) begin
      gate = vecs[v].gated;
      bad0 = bad;
      do_write(vecs[v].val);
      check($sformatf("v%0d_dout_now", v), 32'(dout), 32'(vecs[v].val));
      check($sformatf("v%0d_active_now", v), 32'(active), 32'd1);
      wait_idle($sformatf("v%0d_timeout", v), 400);
      check($sformatf("v%0d_first_adr", v), 32'(first_rd_adr), 32'({vecs[v].exp_hi, 8'h00}));
      check($sformatf("v%0d_rd_lat", v), 32'(first_rd_m - wr_m), 32'd2);
      check($sformatf("v%0d_wr_lat", v), 32'(first_wr_m - wr_m), 32'd3);
      check($sformatf("v%0d_last_wr", v), 32'(last_wr_m - wr_m), 32'd162);
      check($sformatf("v%0d_act_cnt", v), 32'(act_cnt), 32'd162);
      check($sformatf("v%0d_wr_cnt", v), 32'(wr_cnt), 32'd160);
      check($sformatf("v%0d_seq_bad", v), 32'(bad - bad0), 32'd0);
      check($sformatf("v%0d_oam", v), 32'(oam_mismatches(vecs[v].exp_hi)), 32'd0);
      check($sformatf("v%0d_dout_end", v), 32'(dout), 32'(vecs[v].val));
      check($sformatf("v%0d_end_wr", v), 32'(oam_wr), 32'd0);
      gate = 1'b0;
      repeat (2) mstep();
    end

    // Restart at idx 50: 0x80 then 0xC0
    bad0 = bad;
    do_write(8'h80);
    a0 = act_total;
    m0 = mcnt;
    n  = 0;
    while (!(bus_rd && bus_adr[7:0] == 8'd50) && n < 100) begin
      mstep();
      n++;
    end
    check("rs_reach_idx50", 32'(bus_adr), 32'h8032);
    do_write(8'hC0);
    check("rs_active", 32'(active), 32'd1);
    check("rs_no_wr",  32'(oam_wr), 32'd0);
    check("rs_no_rd",  32'(bus_rd), 32'd0);
    check("rs_dout",   32'(dout),   32'hC0);
    wait_idle("rs_timeout", 400);
    check("rs_no_drop",  32'(act_total - a0), 32'(mcnt - m0));
    check("rs_one_start", 32'(idle_gap), 32'd1);
    check("rs_wr_cnt",   32'(wr_cnt), 32'd160);
    check("rs_last_wr",  32'(last_wr_m - wr_m), 32'd162);
    check("rs_seq_bad",  32'(bad - bad0), 32'd0);
    check("rs_oam",      32'(oam_mismatches(8'hC0)), 32'd0);
    repeat (2) mstep();

    // Write landing on the DRAIN cycle
    bad0 = bad;
    do_write(8'h33);
    n = 0;
    while (!(oam_wr && oam_adr == 8'h9F) && n < 300) begin
      mstep();
      n++;
    end
    check("dr_reach_drain", 32'({oam_wr, oam_adr}), 32'h19F);
    do_write(8'h44);
    check("dr_wr_suppressed", 32'(oam_wr), 32'd0);
    check("dr_active",  32'(active), 32'd1);
    check("dr_dout",    32'(dout),   32'h44);
    wait_idle("dr_timeout", 400);
    check("dr_wr_cnt",  32'(wr_cnt), 32'd160);
    check("dr_seq_bad", 32'(bad - bad0), 32'd0);
    check("dr_oam",     32'(oam_mismatches(8'h44)), 32'd0);
    repeat (2) mstep();

    // Reset at idx 80, applied with ce low
    do_write(8'h40);
    n = 0;
    while (!(bus_rd && bus_adr[7:0] == 8'd80) && n < 200) begin
      mstep();
      n++;
    end
    check("mr_reach_idx80", 32'(bus_adr), 32'h4050);
    reset = 1'b0;
    ce    = 1'b0;
    @(posedge clk);
    #1;
    check("mr_active", 32'(active), 32'd0);
    check("mr_oam_wr", 32'(oam_wr), 32'd0);
    check("mr_bus_rd", 32'(bus_rd), 32'd0);
    check("mr_dout",   32'(dout),   32'h00);
    w0 = oam_total;
    reset = 1'b1;
    repeat (200) mstep();
    check("mr_no_writes", 32'(oam_total - w0), 32'd0);
    check("mr_idle",      32'(active), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_oam_dma.md
# gb_oam_dma

OAM DMA engine behind IO register 0xff46. A CPU write of value XX starts the engine. It acts as a bus initiator: it reads 160 bytes from XX00–XX9F and writes them to OAM 0x00–0x9F, one byte per M-cycle. It sits beside the IO select decoder, is selected through `sel`, and drives a secondary master port that the bus arbiter gives priority while `active` is high.

## Interface
Parameters:
- `LEN`, 160: bytes per transfer; also the OAM address span.
- `START_DELAY`, 1: idle M-cycles between the register write and the first read.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-low.
- `ce`  in  1  M-cycle enable; all state advances only on `clk` edges with `ce`=1.
- `sel`  in  1  0xff46 selected by the IO decoder.
- `wr`  in  1  CPU write strobe.
- `din`  in  8  CPU write data.
- `dout`  out  8  read-back of the last value written to 0xff46.
- `active`  out  1  transfer in progress; the arbiter blocks the CPU from non-HRAM space.
- `bus_adr`  out  16  source read address.
- `bus_rd`  out  1  source read request.
- `bus_din`  in  8  read data; valid at the `ce` edge that ends a `bus_rd` cycle.
- `oam_adr`  out  8  OAM write index.
- `oam_wr`  out  1  OAM write strobe.
- `oam_dout`  out  8  OAM write data.

## Operation
- States: IDLE, START, XFER, DRAIN.
- Start condition: `sel & wr & ce`. It latches `din` into `src_hi` and `dout`, clears `idx`, loads the delay counter with `START_DELAY`, and moves to START.
  - Applies from any state. A write during START, XFER or DRAIN restarts the transfer.
  - On restart, the old transfer's pending capture or write is discarded.
  - `active` stays 1 across a restart.
- START: `active`=1, no bus activity. The counter decrements each `ce`; when it reaches 0, go to XFER.
- XFER at `idx` i:
  - Drives `bus_rd`=1 and `bus_adr`={fold(`src_hi`), i}.
  - At the `ce` edge it captures `bus_din` into `data_q` and increments `idx`.
  - If i≥1, it also drives `oam_wr`=1, `oam_adr`=i-1, `oam_dout`=`data_q`.
  - At i=LEN-1, go to DRAIN.
- DRAIN: `oam_wr`=1, `oam_adr`=LEN-1, `oam_dout`=`data_q`, `bus_rd`=0; then go to IDLE.
- fold(h): h when h<0xE0, else h−0x20 (echo RAM). 0xFE→0xDE, 0xFF→0xDF.
- `idx` is 8 bits and never exceeds LEN-1, so there is no wrap.
- `oam_adr` is never ≥ LEN.
- `dout` is unaffected by transfer progress and by reads.

## Timing
- Reset values: state IDLE; `active`=0, `bus_rd`=0, `oam_wr`=0, `bus_adr`=0x0000, `oam_adr`=0x00, `oam_dout`=0x00, `dout`=0x00.
- Reset asserted mid-transfer: IDLE on the next `clk` edge regardless of `ce`; no further OAM writes.
- Every output is a registered state function. Outputs are held for the whole `ce` period; consumers sample at the `ce` edge.
- Write in M-cycle T: `active`=1 from T+1.
  - First `bus_rd` at T+1+START_DELAY.
  - First `oam_wr` one M-cycle later.
  - Last `oam_wr` (DRAIN) at T+1+START_DELAY+LEN.
  - `active` falls at T+2+START_DELAY+LEN: 162 M-cycles high with defaults.
- Read-to-write latency is exactly 1 M-cycle, with one OAM write per M-cycle in steady state.
- A write coinciding with the DRAIN cycle: the new write wins, and the DRAIN write is suppressed in the next M-cycle.
- `ce`=0 cycles freeze all state and outputs.

## Structure
- Put state encoding and `OAM_LEN` (=160) in the shared package `gb_pkg`, next to the other IO register addresses (`ADR_DMA` = 0xff46).
- Single module; fold() is a local function.
- No sub-module is needed. Arbitration stays in the existing bus mux.

## Test plan
- Write 0xC1 then idle:
  - first `bus_adr`=0xC100 two M-cycles later;
  - `oam_wr` 160 times with `oam_adr` 0x00..0x9F;
  - `oam_dout` equals the model memory at 0xC100+i;
  - `active` high exactly 162 M-cycles.
- Write 0xFE → `bus_adr` range 0xDE00–0xDE9F.
- Write 0x80 at idx 50, then 0xC0 → OAM 0x00..0x9F ends with C000+i data:
  - `active` never drops;
  - exactly one START cycle with no `oam_wr`.
- `reset`=0 at idx 80 → the next edge shows `active`=0, `oam_wr`=0, `dout`=0x00; no further writes.
- Random `ce` gating (50% duty) → same OAM contents and the same count in M-cycles as the first scenario.
- Write 0x12 → `dout`=0x12 immediately after the write and after completion.
